mantissa_pp_generator_28x28: RTL and testbench

//  Producer side of the 28x28 mantissa Wallace-tree interface. Splits two 28-bit mantissas

---
 rtl/mantissa_pp_generator_28x28_if.sv | 32 +++
 rtl/mantissa_pp_generator_28x28.sv | 144 ++++++++++++++
 tb/tb_mantissa_pp_generator_28x28.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mantissa_pp_generator_28x28_if.sv
// Operand/result handshake bundle between the mantissa partial-product
// producer and the Wallace tree that consumes its register bank.
interface mantissa_pp_generator_28x28_if;
    logic        in_valid;
    logic        in_ready;
    logic [27:0] a;
    logic [27:0] b;
    logic [1:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] pp11, pp12, pp13, pp14;
    logic [13:0] pp21, pp22, pp23, pp24;
    logic [13:0] pp31, pp32, pp33, pp34;
    logic [13:0] pp41, pp42, pp43, pp44;
    logic [1:0]  op_out;

    // Driver of operands and consumer of the partial-product bank.
    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, op_out,
        input  pp11, pp12, pp13, pp14, pp21, pp22, pp23, pp24,
        input  pp31, pp32, pp33, pp34, pp41, pp42, pp43, pp44
    );

    // The partial-product generator itself.
    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, op_out,
        output pp11, pp12, pp13, pp14, pp21, pp22, pp23, pp24,
        output pp31, pp32, pp33, pp34, pp41, pp42, pp43, pp44
    );
endinterface

// File: rtl/mantissa_pp_generator_28x28.sv
// 28x28 mantissa partial-product generator: splits a/b into four 7-bit
// digits and fills a 16-entry PP bank over 16/MULTS_PER_CYCLE cycles using
// MULTS_PER_CYCLE shared 7x7 multipliers, with SIMD lane masking by op.
module mantissa_pp_generator_28x28 #(
    parameter int unsigned MULTS_PER_CYCLE = 4
) (
    input logic                          clk,
    input logic                          rst,
    mantissa_pp_generator_28x28_if.slave bus
);
    localparam int unsigned M        = MULTS_PER_CYCLE;
    localparam int unsigned CYCLES   = 16 / M;
    localparam logic [3:0]  LAST_CNT = 4'(CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [27:0] a_q, a_d;
    logic [27:0] b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic [13:0] pp_q [16];
    logic [13:0] pp_d [16];

    logic [3:0]  blk   [M];
    logic [6:0]  mul_a [M];
    logic [6:0]  mul_b [M];
    logic [13:0] prod  [M];
    logic        in_ready;
    logic        accept;

    function automatic logic [6:0] digit(input logic [27:0] v, input logic [1:0] idx);
        case (idx)
            2'd0:    digit = v[6:0];
            2'd1:    digit = v[13:7];
            2'd2:    digit = v[20:14];
            default: digit = v[27:21];
        endcase
    endfunction

    // Block k = 4*i + j (0-based digits): k[3:2] is the A digit, k[1:0] the B digit.
    function automatic logic lane_keep(input logic [3:0] k, input logic [1:0] mode);
        case (mode)
            2'b01:   lane_keep = (k[3] == k[1]);
            2'b10:   lane_keep = (k[3:2] == k[1:0]);
            default: lane_keep = 1'b1;
        endcase
    endfunction

    // Shared multipliers: slot s serves block cnt*M+s in the current cycle.
    always_comb begin
        for (int unsigned s = 0; s < M; s++) begin
            blk[s]   = 4'(cnt_q * M + s);
            mul_a[s] = digit(a_q, blk[s][3:2]);
            mul_b[s] = digit(b_q, blk[s][1:0]);
            prod[s]  = {7'd0, mul_a[s]} * {7'd0, mul_b[s]};
        end
    end

    // Next-state, handshake, operand capture and bank write-back.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        pp_d     = pp_q;
        in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
        accept   = bus.in_valid && in_ready;

        case (state_q)
            CALC: begin
                // Each bank entry has a fixed slot and cycle; mux the slot result in.
                for (int unsigned k = 0; k < 16; k++) begin
                    if (4'(k / M) == cnt_q) begin
                        pp_d[k] = lane_keep(4'(k), op_q) ? prod[k % M] : '0;
                    end
                end
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        if (accept) begin
            a_d     = bus.a;
            b_d     = bus.b;
            op_d    = (bus.op == 2'b11) ? 2'b00 : bus.op;
            cnt_d   = '0;
            state_d = CALC;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            pp_q    <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            pp_q    <= pp_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.op_out    = op_q;
    assign bus.pp11 = pp_q[0];
    assign bus.pp12 = pp_q[1];
    assign bus.pp13 = pp_q[2];
    assign bus.pp14 = pp_q[3];
    assign bus.pp21 = pp_q[4];
    assign bus.pp22 = pp_q[5];
    assign bus.pp23 = pp_q[6];
    assign bus.pp24 = pp_q[7];
    assign bus.pp31 = pp_q[8];
    assign bus.pp32 = pp_q[9];
    assign bus.pp33 = pp_q[10];
    assign bus.pp34 = pp_q[11];
    assign bus.pp41 = pp_q[12];
    assign bus.pp42 = pp_q[13];
    assign bus.pp43 = pp_q[14];
    assign bus.pp44 = pp_q[15];
endmodule

// File: tb/tb_mantissa_pp_generator_28x28.sv
// Directed bench for mantissa_pp_generator_28x28 with a scoreboard of
// expected PP banks built from an independent digit/lane model.
module tb_mantissa_pp_generator_28x28;
    localparam int unsigned M   = 4;
    localparam int unsigned LAT = 16 / M + 1;  // edges counted including the accept edge

    typedef struct {
        logic [223:0] pp;
        logic [1:0]   op;
        logic [27:0]  a;
        logic [27:0]  b;
    } exp_t;

    typedef struct {
        logic [27:0] a;
        logic [27:0] b;
        logic [1:0]  op;
    } stim_t;

    logic clk = 1'b0;
    logic rst;

    mantissa_pp_generator_28x28_if bus ();

    mantissa_pp_generator_28x28 #(.MULTS_PER_CYCLE(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    stim_t       stim_q[$];
    int unsigned cyc = 0;
    int unsigned acc_cyc = 0;
    bit          lat_pending = 1'b0;

    function automatic logic [223:0] dut_bank();
        return {bus.pp44, bus.pp43, bus.pp42, bus.pp41,
                bus.pp34, bus.pp33, bus.pp32, bus.pp31,
                bus.pp24, bus.pp23, bus.pp22, bus.pp21,
                bus.pp14, bus.pp13, bus.pp12, bus.pp11};
    endfunction

    function automatic exp_t model(input logic [27:0] a, input logic [27:0] b, input logic [1:0] op);
        exp_t        e;
        logic [27:0] sa, sb;
        bit          keep;
        int          p;
        e.pp = '0;
        e.a  = a;
        e.b  = b;
        e.op = (op == 2'b11) ? 2'b00 : op;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                sa = a >> (7 * i);
                sb = b >> (7 * j);
                case (op)
                    2'b01:   keep = ((i < 2) == (j < 2));
                    2'b10:   keep = (i == j);
                    default: keep = 1'b1;
                endcase
                p = int'(sa[6:0]) * int'(sb[6:0]);
                e.pp[14*(4*i+j) +: 14] = keep ? 14'(p) : 14'd0;
            end
        end
        return e;
    endfunction

    function automatic logic [55:0] tree_sum(input logic [223:0] bank);
        logic [55:0] s = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = s + (56'(bank[14*(4*i+j) +: 14]) << (7 * (i + j)));
            end
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_front();
        if (stim_q.size() != 0) begin
            bus.in_valid = 1'b1;
            bus.a        = stim_q[0].a;
            bus.b        = stim_q[0].b;
            bus.op       = stim_q[0].op;
        end else begin
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic push(input logic [27:0] a, input logic [27:0] b, input logic [1:0] op);
        stim_t s;
        s.a  = a;
        s.b  = b;
        s.op = op;
        stim_q.push_back(s);
        drive_front();
    endtask

    // One clock: score any handshakes due at this edge, then advance.
    task automatic step();
        bit    acc, con;
        exp_t  e;
        stim_t s;
        #1;
        acc = bus.in_valid && bus.in_ready;
        con = bus.out_valid && bus.out_ready;
        if (con) begin
            check("output_has_expectation", 256'(exp_q.size() != 0), 256'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pp_bank", 256'(dut_bank()), 256'(e.pp));
                check("op_out", 256'(bus.op_out), 256'(e.op));
                if (e.op == 2'b00)
                    check("tree_sum", 256'(tree_sum(dut_bank())), 256'({28'd0, e.a} * {28'd0, e.b}));
            end
        end
        if (acc) begin
            s = stim_q.pop_front();
            exp_q.push_back(model(s.a, s.b, s.op));
            acc_cyc     = cyc;
            lat_pending = 1'b1;
        end
        @(posedge clk);
        cyc++;
        #1;
        drive_front();
        if (lat_pending && bus.out_valid) begin
            check("latency", 256'(cyc - acc_cyc), 256'(LAT));
            lat_pending = 1'b0;
        end
    endtask

    task automatic drain(input int max_cycles);
        for (int n = 0; n < max_cycles && (exp_q.size() != 0 || stim_q.size() != 0); n++) step();
        check("drain_complete", 256'(exp_q.size() + stim_q.size()), 256'(0));
        check("idle_out_valid", 256'(bus.out_valid), 256'(0));
        check("idle_in_ready", 256'(bus.in_ready), 256'(1));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, 256'(bus.out_valid), 256'(0));
        check({tag, "_in_ready"}, 256'(bus.in_ready), 256'(1));
        check({tag, "_bank"}, 256'(dut_bank()), 256'(0));
        check({tag, "_op_out"}, 256'(bus.op_out), 256'(0));
    endtask

    initial begin
        exp_t held;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        // Directed operands plus a few random ones, streamed back-to-back.
        push(28'hFFFFFFF, 28'hFFFFFFF, 2'b00);
        push(28'h0204081, 28'h0204081, 2'b10);
        push(28'h0000FFF, 28'h0003FFF, 2'b01);
        push(28'h0000FFF, 28'h0000FFF, 2'b01);
        push(28'(32'($urandom)), 28'(32'($urandom)), 2'b11);
        push(28'(32'($urandom)), 28'(32'($urandom)), 2'b00);
        push(28'(32'($urandom)), 28'(32'($urandom)), 2'b01);
        push(28'(32'($urandom)), 28'(32'($urandom)), 2'b10);
        drain(200);

        // Backpressure: bank must hold and the second operand must wait.
        bus.out_ready = 1'b0;
        push(28'h5A5A5A5, 28'h3C3C3C3, 2'b00);
        push(28'h1234567, 28'h7654321, 2'b01);
        for (int n = 0; n < 50 && !bus.out_valid; n++) step();
        check("stall_out_valid", 256'(bus.out_valid), 256'(1));
        held = model(28'h5A5A5A5, 28'h3C3C3C3, 2'b00);
        for (int n = 0; n < 10; n++) begin
            step();
            check("stall_bank", 256'(dut_bank()), 256'(held.pp));
            check("stall_op_out", 256'(bus.op_out), 256'(held.op));
            check("stall_in_ready", 256'(bus.in_ready), 256'(0));
            check("stall_no_accept", 256'(exp_q.size()), 256'(1));
        end
        bus.out_ready = 1'b1;
        drain(100);

        // Reset in CALC cycle 2 discards the operation.
        push(28'h7FFFFFF, 28'h0ABCDEF, 2'b00);
        for (int n = 0; n < 10 && stim_q.size() != 0; n++) step();
        step();
        step();
        rst = 1'b1;
        #1;
        check_reset_state("midcalc_reset");
        exp_q.delete();
        stim_q.delete();
        lat_pending  = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(28'h2468ACE, 28'h13579BD, 2'b00);
        drain(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
